// File: rtl/ysyx_210247_if_fetch_if.sv
// IF-stage port bundle: redirect input, instruction-memory request/response,
// and the IF->ID valid/allow bus.
interface ysyx_210247_if_fetch_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned INST_W = 32,
    parameter int unsigned BUS_W  = XLEN + INST_W
);
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              if_valid_out;
    logic [BUS_W-1:0]  if_to_id_bus_o;
    logic              if_allow_out;

    // Fetch stage side
    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_valid_out, if_to_id_bus_o,
        input  if_allow_out
    );

    // Memory / decode / control side
    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_valid_out, if_to_id_bus_o,
        output if_allow_out
    );
endinterface

// File: rtl/ysyx_210247_if_fetch.sv
// Instruction-fetch stage: one outstanding imem request, buffers the returned
// instruction and offers {pc, inst} to ID; redirects retarget and drop stale data.
module ysyx_210247_if_fetch #(
    parameter int unsigned        XLEN     = 64,
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        BUS_W    = XLEN + INST_W,
    parameter logic [XLEN-1:0]    PC_RESET = 64'h8000_0000
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_210247_if_fetch_if.master fetch_bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [BUS_W-1:0]  buf_q, buf_d;
    logic              drop_q, drop_d;
    logic              req_valid_q;
    logic              hold_valid_q;

    logic              redirect_c;
    logic              resp_c;
    logic              req_fire_c;
    logic [XLEN-1:0]   target_c;

    assign redirect_c = fetch_bus.redirect_valid;
    assign resp_c     = fetch_bus.imem_resp_valid;
    assign req_fire_c = (state_q == REQ) && fetch_bus.imem_req_ready;
    assign target_c   = {fetch_bus.redirect_pc[XLEN-1:2], 2'b00};

    // Next-state, PC, buffer and drop bookkeeping
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_fire_c) begin
                    state_d = (drop_q || redirect_c) ? DROP : WAIT;
                end else if (redirect_c) begin
                    // request already on the wire: keep address, drop its response later
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (resp_c) begin
                    if (redirect_c) begin
                        state_d = REQ;
                    end else begin
                        buf_d   = {pc_q, fetch_bus.imem_resp_data};
                        state_d = HOLD;
                    end
                end else if (redirect_c) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (resp_c) begin
                    drop_d  = 1'b0;
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_c) begin
                    buf_d   = '0;
                    state_d = REQ;
                end else if (fetch_bus.if_allow_out) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_c) begin
            pc_d = target_c;
        end
        // Address is captured only on entry to REQ so it stays stable until accepted
        if ((state_d == REQ) && (state_q != REQ)) begin
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= PC_RESET;
            addr_q       <= PC_RESET;
            buf_q        <= '0;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            buf_q        <= buf_d;
            drop_q       <= drop_d;
            req_valid_q  <= (state_d == REQ);
            hold_valid_q <= (state_d == HOLD);
        end
    end

    assign fetch_bus.imem_req_valid = req_valid_q;
    assign fetch_bus.imem_req_addr  = addr_q;
    // A redirect kills the offer in the same cycle so ID never takes a stale instruction
    assign fetch_bus.if_valid_out   = hold_valid_q && !redirect_c;
    assign fetch_bus.if_to_id_bus_o = buf_q;

endmodule

// File: tb/tb_ysyx_210247_if_fetch.sv
// Scoreboard bench for ysyx_210247_if_fetch: directed scenarios push expected
// request addresses and IF->ID payloads; memory model and monitor pop and compare.
module tb_ysyx_210247_if_fetch;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned BUS_W  = 96;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_210247_if_fetch_if #(.XLEN(XLEN), .INST_W(INST_W), .BUS_W(BUS_W)) bus_if ();

    ysyx_210247_if_fetch #(
        .XLEN(XLEN), .INST_W(INST_W), .BUS_W(BUS_W), .PC_RESET(64'h8000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_bus (bus_if)
    );

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;
    int n_xfer = 0;
    int resp_delay = 1;
    int mem_cnt = 0;
    logic [XLEN-1:0]  mem_addr = '0;
    logic [XLEN-1:0]  exp_addr_q [$];
    logic [BUS_W-1:0] exp_bus_q [$];
    logic [BUS_W-1:0] prev_bus = '0;
    bit               stall_prev = 1'b0;

    task automatic check(input bit ok, input string name,
                         input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit reached(input int which, input int target);
        case (which)
            0:       return n_acc >= target;
            1:       return n_xfer >= target;
            default: return bus_if.if_valid_out == 1'b1;
        endcase
    endfunction

    task automatic wait_until(input int which, input int target, input string name);
        int n = 0;
        while (!reached(which, target) && n < 60) begin
            step(1);
            n++;
        end
        check(reached(which, target), name, BUS_W'(n), BUS_W'(60));
    endtask

    // Memory model: accepts on valid&&ready, answers resp_delay cycles later
    initial begin
        bus_if.imem_resp_valid = 1'b0;
        bus_if.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            bus_if.imem_resp_valid = 1'b0;
            if (!rst) begin
                mem_cnt = 0;
            end else begin
                if (mem_cnt > 0) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        bus_if.imem_resp_valid = 1'b1;
                        bus_if.imem_resp_data  = mem_addr[31:0] ^ 32'hDEAD_0000;
                    end
                end
                if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
                    n_acc++;
                    if (exp_addr_q.size() == 0) begin
                        check(1'b0, "req_addr_unexpected", BUS_W'(bus_if.imem_req_addr), '0);
                    end else begin
                        logic [XLEN-1:0] e;
                        e = exp_addr_q.pop_front();
                        check(bus_if.imem_req_addr == e, "req_addr",
                              BUS_W'(bus_if.imem_req_addr), BUS_W'(e));
                    end
                    mem_addr = bus_if.imem_req_addr;
                    mem_cnt  = resp_delay;
                end
            end
        end
    end

    // IF->ID monitor: transfers, stall stability, no request while holding
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.if_valid_out) begin
                check(!bus_if.imem_req_valid, "no_req_in_hold",
                      BUS_W'(bus_if.imem_req_valid), '0);
                if (bus_if.if_allow_out) begin
                    n_xfer++;
                    stall_prev = 1'b0;
                    if (exp_bus_q.size() == 0) begin
                        check(1'b0, "bus_unexpected", bus_if.if_to_id_bus_o, '0);
                    end else begin
                        logic [BUS_W-1:0] e;
                        e = exp_bus_q.pop_front();
                        check(bus_if.if_to_id_bus_o == e, "bus", bus_if.if_to_id_bus_o, e);
                    end
                end else begin
                    if (stall_prev) begin
                        check(bus_if.if_to_id_bus_o == prev_bus, "bus_stable",
                              bus_if.if_to_id_bus_o, prev_bus);
                    end
                    prev_bus   = bus_if.if_to_id_bus_o;
                    stall_prev = 1'b1;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = '0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.if_allow_out   = 1'b1;
        step(3);
        check(bus_if.imem_req_valid == 1'b0, "rst_req_valid", BUS_W'(bus_if.imem_req_valid), '0);
        check(bus_if.if_valid_out == 1'b0, "rst_if_valid", BUS_W'(bus_if.if_valid_out), '0);

        // Streaming fetch from the reset vector
        exp_addr_q.push_back(64'h8000_0000);
        exp_addr_q.push_back(64'h8000_0004);
        exp_addr_q.push_back(64'h8000_0008);
        exp_bus_q.push_back({64'h8000_0000, 32'h5EAD_0000});
        exp_bus_q.push_back({64'h8000_0004, 32'h5EAD_0004});
        exp_bus_q.push_back({64'h8000_0008, 32'h5EAD_0008});
        rst = 1'b1;
        wait_until(0, 3, "t1_acc_timeout");
        bus_if.imem_req_ready = 1'b0;
        wait_until(1, 3, "t1_xfer_timeout");

        // Backpressure in HOLD
        exp_addr_q.push_back(64'h8000_000C);
        exp_bus_q.push_back({64'h8000_000C, 32'h5EAD_000C});
        bus_if.if_allow_out   = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        wait_until(0, 4, "t2_acc_timeout");
        bus_if.imem_req_ready = 1'b0;
        wait_until(2, 0, "t2_hold_timeout");
        step(4);
        check(bus_if.if_valid_out == 1'b1, "t2_valid_held", BUS_W'(bus_if.if_valid_out), BUS_W'(1));
        check(bus_if.if_to_id_bus_o == {64'h8000_000C, 32'h5EAD_000C}, "t2_bus_held",
              bus_if.if_to_id_bus_o, {64'h8000_000C, 32'h5EAD_000C});
        exp_addr_q.push_back(64'h8000_0010);
        bus_if.if_allow_out = 1'b1;
        wait_until(1, 4, "t2_xfer_timeout");
        check(bus_if.imem_req_valid && bus_if.imem_req_addr == 64'h8000_0010, "t2_next_addr",
              BUS_W'(bus_if.imem_req_addr), BUS_W'(64'h8000_0010));

        // Redirect while waiting for the response
        resp_delay = 3;
        bus_if.imem_req_ready = 1'b1;
        wait_until(0, 5, "t3_acc_timeout");
        bus_if.imem_req_ready = 1'b0;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 64'h8000_1002;
        step(1);
        bus_if.redirect_valid = 1'b0;
        exp_addr_q.push_back(64'h8000_1000);
        exp_bus_q.push_back({64'h8000_1000, 32'h5EAD_1000});
        resp_delay = 1;
        bus_if.imem_req_ready = 1'b1;
        wait_until(0, 6, "t3_acc_timeout2");
        bus_if.imem_req_ready = 1'b0;
        wait_until(1, 5, "t3_xfer_timeout");

        // Redirect while the request is stalled by ready=0
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 64'h8000_2000;
        step(1);
        bus_if.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check(bus_if.imem_req_valid && bus_if.imem_req_addr == 64'h8000_1004, "t4_addr_held",
                  BUS_W'(bus_if.imem_req_addr), BUS_W'(64'h8000_1004));
            if (i < 2) step(1);
        end
        exp_addr_q.push_back(64'h8000_1004);
        exp_addr_q.push_back(64'h8000_2000);
        exp_bus_q.push_back({64'h8000_2000, 32'h5EAD_2000});
        bus_if.imem_req_ready = 1'b1;
        wait_until(0, 8, "t4_acc_timeout");
        bus_if.imem_req_ready = 1'b0;
        wait_until(1, 6, "t4_xfer_timeout");

        // Redirect and allow in the same HOLD cycle
        exp_addr_q.push_back(64'h8000_2004);
        bus_if.if_allow_out   = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        wait_until(0, 9, "t5_acc_timeout");
        bus_if.imem_req_ready = 1'b0;
        wait_until(2, 0, "t5_hold_timeout");
        bus_if.if_allow_out   = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 64'h8000_3000;
        #1;
        check(bus_if.if_valid_out == 1'b0, "t5_valid_gated", BUS_W'(bus_if.if_valid_out), '0);
        step(1);
        bus_if.redirect_valid = 1'b0;
        check(bus_if.imem_req_valid && bus_if.imem_req_addr == 64'h8000_3000, "t5_target_addr",
              BUS_W'(bus_if.imem_req_addr), BUS_W'(64'h8000_3000));

        // Reset while a response is outstanding
        exp_addr_q.push_back(64'h8000_3000);
        resp_delay = 3;
        bus_if.imem_req_ready = 1'b1;
        wait_until(0, 10, "t6_acc_timeout");
        bus_if.imem_req_ready = 1'b0;
        rst = 1'b0;
        step(1);
        check(bus_if.imem_req_valid == 1'b0, "t6_rst_req_valid", BUS_W'(bus_if.imem_req_valid), '0);
        check(bus_if.if_valid_out == 1'b0, "t6_rst_if_valid", BUS_W'(bus_if.if_valid_out), '0);
        rst = 1'b1;
        resp_delay = 1;
        exp_addr_q.push_back(64'h8000_0000);
        exp_bus_q.push_back({64'h8000_0000, 32'h5EAD_0000});
        bus_if.imem_req_ready = 1'b1;
        wait_until(0, 11, "t6_acc_timeout2");
        bus_if.imem_req_ready = 1'b0;
        wait_until(1, 7, "t6_xfer_timeout");

        step(2);
        check(exp_addr_q.size() == 0, "addr_queue_drained", BUS_W'(exp_addr_q.size()), '0);
        check(exp_bus_q.size() == 0, "bus_queue_drained", BUS_W'(exp_bus_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_210247_if_fetch.md
Name: ysyx_210247_if_fetch

Overview:
- Instruction-fetch producer stage that drives the IF→ID valid/allow handshake from the upstream side.
- Holds the PC and issues one outstanding fetch request at a time to the instruction-memory port (valid/ready request, valid response).
- Buffers the returned instruction and presents {pc, inst} on the IF→ID bus until the pipeline register accepts it.
- Handles redirects (branch/trap/flush) by retargeting the PC and discarding any stale in-flight response.

Parameters:
PC_RESET, 64'h8000_0000, PC value loaded on reset
XLEN, 64, PC/address width
INST_W, 32, instruction width
BUS_W, 96, IF→ID bus width = XLEN+INST_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-low reset (rst==0 resets)
redirect_valid  in  1  flush current fetch, restart at redirect_pc
redirect_pc  in  XLEN  new PC; bits [1:0] ignored, treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_resp_valid  in  1  response data valid (one-cycle pulse, one per accepted request)
imem_resp_data  in  INST_W  fetched instruction
if_valid_out  out  1  IF→ID bus holds valid {pc,inst}
if_to_id_bus_o  out  BUS_W  {pc[63:0], inst[31:0]}
if_allow_out  in  1  downstream register accepts this cycle

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, pc=PC_RESET, drop_pending=0, buffer cleared to 0.
  - imem_req_valid=0, if_valid_out=0.
- States: IDLE, REQ, WAIT, DROP, HOLD.
- IDLE: always → REQ next cycle.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Address is held stable while valid && !ready.
  - On valid&&ready: → WAIT, or → DROP if drop_pending or redirect_valid in this cycle.
- WAIT: on imem_resp_valid, latch {pc, imem_resp_data} into buffer → HOLD. A response may arrive the cycle after acceptance or later.
- HOLD:
  - if_valid_out=1, bus=buffer.
  - Transfer when if_allow_out=1: pc<=pc+4 (64-bit wrap), → REQ.
  - Otherwise hold; bus stays stable.
- DROP: wait for imem_resp_valid, discard data, clear drop_pending, → REQ. pc already holds the redirect target.
- Redirect (redirect_valid=1), highest priority. Always pc<=redirect_pc&~3. Then, by state:
  - IDLE: → REQ.
  - REQ, no handshake this cycle: set drop_pending=1, stay REQ with the old address. The next acceptance goes to DROP, then a new REQ with the target.
  - REQ, handshake this cycle: → DROP.
  - WAIT: → DROP. If resp_valid arrives in the same cycle, the response is discarded and the state → REQ directly.
  - DROP: stay DROP.
  - HOLD: drop buffer, → REQ.
- Redirect and if_allow_out in the same cycle: redirect wins, no pc+4. if_valid_out is combinationally gated to 0 while redirect_valid=1.
- At most one request outstanding; imem_req_valid is never 1 outside REQ.
- Latency: acceptance at cycle N, response at N+k → if_valid_out from N+k+1.
- Throughput: with zero stall, 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Reset mid-operation: immediate return to IDLE. Any later response for the aborted request is the memory side's responsibility; the block must not hang.

Test Plan:
- Reset release, ready=1, response 1 cycle after acceptance, allow=1 → addresses 0x80000000, 0x80000004, 0x80000008; bus = {0x80000000, resp0} valid exactly one cycle each.
- Backpressure: allow=0 for 5 cycles in HOLD → if_valid_out and bus stable; no imem_req_valid. After allow=1, next req addr = pc+4.
- Redirect in WAIT to 0x80001002 → the in-flight response is discarded, never visible on the bus. Next req addr = 0x80001000, bus pc = 0x80001000.
- Redirect in REQ with ready=0 for 3 cycles → old addr held stable until accepted, its response dropped, then request to the target.
- Redirect and allow same cycle in HOLD → if_valid_out=0 that cycle, pc = target (not pc+4).
- Reset asserted in WAIT → next cycle imem_req_valid=0, if_valid_out=0, pc=PC_RESET; fetch restarts at 0x80000000.
